gate_sweep_checker: RTL
=======================

// Module: gate_sweep_checker
// PURPOSE
// - Synthesizable stimulus-and-response end for small combinational gates, such as the 2-input and-gate.
// - Sweeps every input vector 0 .. 2**N_IN-1 onto the DUT and waits a settle window.
// - Samples the DUT output, compares it against a truth-table parameter, counts mismatches and reports pass/fail.
// - Sits beside the gate under test, in FPGA self-test or in a bench top level.
// PARAMETERS
// - N_IN           default 2        number of DUT inputs; legal range 1..4.
// - SETTLE_CYCLES  default 1        cycles held per vector before sampling; must be >=1.
// - EXPECT_TT      default 4'b1000  width 2**N_IN; bit i = expected y for input vector i (and2).
// PORTS
// - clk               in   1          rising-edge clock
// - rst               in   1          asynchronous, active-high reset
// - start             in   1          begin sweep; honoured only in IDLE
// - stim              out  N_IN       DUT input vector; stim[0]=a, stim[1]=b
// - dut_y             in   1          DUT output, sampled in SAMPLE
// - busy              out  1          high in SETTLE and SAMPLE
// - done              out  1          one-cycle pulse at end of sweep
// - pass              out  1          err_count==0 at sweep end; held until next start
// - err_count         out  N_IN+1     mismatches in current/last sweep
// - first_fail_valid  out  1          at least one mismatch recorded
// - first_fail_vec    out  N_IN       lowest vector that mismatched
// BEHAVIOUR
// - Reset (any time, including mid-sweep):
//   - state=IDLE; stim, busy, done, pass, err_count, first_fail_* all 0.
//   - Effect is immediate, no clock needed.
// - FSM states: IDLE -> SETTLE -> SAMPLE -> (SETTLE | DONE) -> IDLE.
// - IDLE, start=1 at edge E0:
//   - clear err_count, pass, first_fail_*; vec=0, stim=0, settle_cnt=0.
//   - go to SETTLE.
// - SETTLE: stim held stable; stays SETTLE_CYCLES cycles, then SAMPLE.
// - SAMPLE (1 cycle): mismatch = (dut_y != EXPECT_TT[vec]).
//   - On mismatch, err_count+1.
//   - If first_fail_valid was 0, set first_fail_valid=1 and first_fail_vec=vec.
//   - vec == 2**N_IN-1: go to DONE.
//   - Otherwise vec+1, stim=vec+1, settle_cnt=0, go to SETTLE.
// - DONE (1 cycle): done=1; pass=(err_count==0) including the final sample; next state IDLE.
// - Outputs: all outputs are registered.
// - Latency: done is high in cycle 1 + 2**N_IN*(SETTLE_CYCLES+1) after E0.
//   - With defaults, done is high in cycle 9.
// - Width rule: err_count is N_IN+1 bits and holds up to 2**N_IN, so it never wraps; no saturation logic.
// - start while busy, or in the DONE cycle: ignored, no restart, no state change.
// - stim returns to 0 in IDLE after DONE.
// - err_count and first_fail_* hold until the next accepted start.
// STRUCTURE
// - Package gate_check_pkg:
//   - state_t enum {IDLE, SETTLE, SAMPLE, DONE}.
//   - Truth-table constants TT_AND2=4'b1000, TT_OR2=4'b1110, TT_XOR2=4'b0110, TT_NAND2=4'b0111.
// - One sub-module, gate_check_settle_timer: loadable down-counter with an expired flag, used for the SETTLE window.
// - The rest is flat in this module.
// TESTING
// - Defaults, DUT=and-gate, start pulse at E0:
//   - stim steps 00,01,10,11, each held 2 cycles.
//   - done at cycle 9; pass=1, err_count=0, first_fail_valid=0.
// - DUT output tied to 1:
//   - err_count=3, pass=0, first_fail_valid=1, first_fail_vec=0.
// - DUT replaced by or-gate (EXPECT_TT=TT_AND2):
//   - err_count=2, first_fail_vec=1, pass=0.
// - start re-pulsed at cycle 4, and again in the DONE cycle:
//   - sweep unaffected; done once at cycle 9; no second sweep.
// - rst asserted mid-SETTLE of vector 2:
//   - all outputs 0 immediately.
//   - A new start then gives a full clean sweep with done at cycle 9 relative.
// - SETTLE_CYCLES=3, N_IN=2:
//   - done at cycle 17.
//   - dut_y sampled only in the 4th cycle of each vector: glitch dut_y in cycles 1-3, no error counted.

Source files
------------

// File: rtl/gate_check_pkg.sv
// Shared types and reference truth tables for the gate sweep checker.
// Truth-table bit i is the expected gate output for input vector i (i[0]=a, i[1]=b).
package gate_check_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0] TT_AND2  = 4'b1000;
    localparam logic [3:0] TT_OR2   = 4'b1110;
    localparam logic [3:0] TT_XOR2  = 4'b0110;
    localparam logic [3:0] TT_NAND2 = 4'b0111;

endpackage

// File: rtl/gate_check_settle_timer.sv
// Loadable down-counter timing the settle window; expired is high once the count reaches zero.
module gate_check_settle_timer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         expired
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: load wins over decrement, and the counter parks at zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == '0);

endmodule

// File: rtl/gate_sweep_checker.sv
// Drives every input vector onto a small combinational gate, waits a settle window,
// samples its output against a truth table and reports mismatch count and first failing vector.
module gate_sweep_checker
    import gate_check_pkg::*;
#(
    parameter int                      N_IN          = 2,
    parameter int                      SETTLE_CYCLES = 1,
    parameter logic [(1<<N_IN)-1:0]    EXPECT_TT     = TT_AND2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [N_IN-1:0] stim,
    input  logic            dut_y,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic            first_fail_valid,
    output logic [N_IN-1:0] first_fail_vec
);

    localparam int TW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);

    state_t          state_q, state_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic [N_IN-1:0] stim_q, stim_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic [N_IN:0]   err_q, err_d;
    logic            ffv_q, ffv_d;
    logic [N_IN-1:0] ffvec_q, ffvec_d;
    logic            tmr_load_s;
    logic            tmr_dec_s;
    logic            tmr_expired_s;
    logic            mismatch_s;
    logic            last_vec_s;

    gate_check_settle_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load_s),
        .load_val (SETTLE_LOAD),
        .dec      (tmr_dec_s),
        .expired  (tmr_expired_s)
    );

    assign last_vec_s = (vec_q == {N_IN{1'b1}});

    // Sweep sequencing; outputs are computed one cycle ahead so they can be registered.
    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        stim_d     = stim_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        pass_d     = pass_q;
        err_d      = err_q;
        ffv_d      = ffv_q;
        ffvec_d    = ffvec_q;
        tmr_load_s = 1'b0;
        tmr_dec_s  = 1'b0;
        mismatch_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    err_d      = '0;
                    pass_d     = 1'b0;
                    ffv_d      = 1'b0;
                    ffvec_d    = '0;
                    vec_d      = '0;
                    stim_d     = '0;
                    busy_d     = 1'b1;
                    tmr_load_s = 1'b1;
                    state_d    = SETTLE;
                end else begin
                    state_d = IDLE;
                end
            end
            SETTLE: begin
                if (tmr_expired_s) begin
                    state_d = SAMPLE;
                end else begin
                    tmr_dec_s = 1'b1;
                end
            end
            SAMPLE: begin
                mismatch_s = (dut_y != EXPECT_TT[vec_q]);
                if (mismatch_s) begin
                    err_d = err_q + (N_IN+1)'(1);
                    if (!ffv_q) begin
                        ffv_d   = 1'b1;
                        ffvec_d = vec_q;
                    end else begin
                        ffv_d   = ffv_q;
                    end
                end else begin
                    err_d = err_q;
                end
                if (last_vec_s) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == '0);
                    state_d = DONE;
                end else begin
                    vec_d      = vec_q + N_IN'(1);
                    stim_d     = vec_q + N_IN'(1);
                    tmr_load_s = 1'b1;
                    state_d    = SETTLE;
                end
            end
            DONE: begin
                stim_d  = '0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                stim_d  = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= '0;
            stim_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            ffv_q   <= 1'b0;
            ffvec_q <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            stim_q  <= stim_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            ffv_q   <= ffv_d;
            ffvec_q <= ffvec_d;
        end
    end

    assign stim             = stim_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign err_count        = err_q;
    assign first_fail_valid = ffv_q;
    assign first_fail_vec   = ffvec_q;

endmodule
